// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings and request checks for the load/store unit
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } lsu_err_e;

    function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
        if (store) begin
            return f3 > F3_W;
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Only meaningful for legal funct3; size is carried in the low two bits.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - core request/response and memory bus signals of the load/store unit
interface lsu_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte enables, store lane replication and load extraction/extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic        store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_o
);

    logic [31:0] shifted;

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
        if (!store_i) begin
            be_o = 4'b0000;
        end
    end

    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    always_comb begin
        load_o = shifted;
        case (funct3_i)
            F3_B:    load_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_o = {24'b0, shifted[7:0]};
            F3_HU:   load_o = {16'b0, shifted[15:0]};
            default: load_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: request FSM, bus handshake and timeout
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    lsu_state_e  state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    lsu_err_e    err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        timeout_hit;
    logic        in_req;
    logic        in_resp;

    lsu_align u_align (
        .store_i   (store_q),
        .funct3_i  (funct3_q),
        .addr_lo_i (addr_q[1:0]),
        .wdata_i   (wdata_q),
        .rdata_i   (bus.mem_rdata),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .load_o    (load_data)
    );

    // Counter holds the number of REQ/WAIT cycles already spent; the last allowed one aborts.
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= ERR_OK;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    store_d  = bus.req_store;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = '0;
                    err_d    = ERR_OK;
                    cnt_d    = '0;
                    if (f3_illegal(bus.req_store, bus.req_funct3)) begin
                        err_d   = ERR_ILLEGAL;
                        state_d = ST_RESP;
                    end else if (misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
                        err_d   = ERR_MISALIGN;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (cnt_q != CW'(TIMEOUT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (timeout_hit) begin
                    err_d   = ERR_TIMEOUT;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else if (bus.mem_gnt) begin
                    // A coincident rvalid is not a response to this request.
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != CW'(TIMEOUT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (timeout_hit) begin
                    err_d   = ERR_TIMEOUT;
                    rdata_d = '0;
                    state_d = ST_RESP;
                end else if (bus.mem_rvalid) begin
                    err_d   = ERR_OK;
                    rdata_d = store_q ? 32'h0 : load_data;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_req  = (state_q == ST_REQ);
    assign in_resp = (state_q == ST_RESP);

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.mem_req    = in_req;
    assign bus.mem_we     = in_req & store_q;
    assign bus.mem_addr   = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.mem_be     = in_req ? lane_be : 4'b0000;
    assign bus.mem_wdata  = in_req ? lane_wdata : 32'h0;
    assign bus.resp_valid = in_resp;
    assign bus.resp_rdata = in_resp ? rdata_q : 32'h0;
    assign bus.resp_err   = in_resp ? err_q : ERR_OK;

endmodule
